banzai_axil_host: RTL
=====================

Name: banzai_axil_host

Overview:
- AXI-Lite master that drives the banzAI control slave from a simple command/response stream.
- Sits between a sequencer or CPU-side command source and the banzAI AXI-Lite slave port.
- Issues one transaction at a time:
  - likelihood memory words at addresses below 0x2000;
  - control registers at 0x2000 + 4*n;
  - result readback at 0x2000.
- Absorbs the slave's long, variable response latency.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width
TIMEOUT_CYCLES, 4096, cycles waited for a B/R response before abort (only with macro)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle
cmd_write  in  1  1: write, 0: read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_data  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI resp code, or 2'b10 on timeout
busy  out  1  transaction in flight
m_aw_addr/m_aw_valid/m_aw_ready  out/out/in  ADDR_WIDTH/1/1  write address channel
m_w_data/m_w_strb/m_w_valid/m_w_ready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
m_b_resp/m_b_valid/m_b_ready  in/in/out  2/1/1  write response channel
m_ar_addr/m_ar_valid/m_ar_ready  out/out/in  ADDR_WIDTH/1/1  read address channel
m_r_data/m_r_resp/m_r_valid/m_r_ready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high. All flops clear on rst regardless of clk.
- Reset values:
  - all valids and readies 0; busy 0;
  - rsp_data 0, rsp_resp 0;
  - address/data output registers 0;
  - m_w_strb all ones.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/data, set busy.
  - Go to WR_REQ when cmd_write=1, else RD_REQ.
  - Bus valids assert the cycle after acceptance (1-cycle latency).
- WR_REQ:
  - m_aw_valid and m_w_valid are asserted together. The slave samples both simultaneously, so neither may wait for the other.
  - Each valid drops independently on its own ready (aw_done/w_done flags).
  - m_b_ready=1 from entry. The slave pulses b_valid for one cycle without waiting for ready, so b_ready must already be high.
  - When both are done, go to WR_RESP. If m_b_valid arrives in the same cycle as the last ready, capture it and go directly to RSP.
- WR_RESP: m_b_ready=1; on m_b_valid capture m_b_resp, rsp_data=0, go to RSP.
- RD_REQ:
  - m_ar_valid=1 until m_ar_ready, then drop it.
  - m_r_ready=1 from entry. The slave only drives r_valid while r_ready is high.
  - Go to RD_RESP after the AR handshake. An m_r_valid in the same cycle is captured and goes directly to RSP.
- RD_RESP: m_r_ready=1; on m_r_valid capture m_r_data/m_r_resp, go to RSP.
- RSP:
  - rsp_valid=1, and m_b_ready/m_r_ready=0.
  - Response held stable until rsp_ready; then go to IDLE and clear busy.
  - A new command may not be accepted in the same cycle rsp_ready is sampled. cmd_ready rises the next cycle.
- Stray responses: any m_b_valid/m_r_valid arriving in IDLE or RSP is ignored.
- No outstanding transactions beyond one; cmd_ready=0 in every non-IDLE state.
- Address is passed through unmodified. Unaligned addresses are forwarded as given; the low 2 bits are the command source's responsibility.
- Reset mid-transaction: all valids drop immediately. No response is generated for the aborted command.

Optional Feature:
- Macro: BANZAI_HOST_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, all bus valids/readies drop and the block goes to RSP with rsp_resp=2'b10 and rsp_data=0.
  - The aborted transaction is not retried.
- Undefined: no counter; the block waits indefinitely for handshakes.

Test Plan:
- Register write cmd_write=1, addr 0x2008, data 0x5; slave holds aw_ready/w_ready low 3 cycles -> AW and W both valid until the same-cycle ready; single rsp with resp 0 and data 0.
- Memory write addr 0x0044, data 0xA5A5A5A5; slave emits a 1-cycle b_valid 140 cycles later -> captured because b_ready was held high; rsp_resp 0.
- Register read addr 0x2004 after writing 1 -> rsp_data 0x1; read of 0x2000 with slave returning 0x0A0B0C0D after 200 cycles -> rsp_data 0x0A0B0C0D.
- Back-pressure: rsp_ready held low 10 cycles -> rsp_valid, rsp_data and rsp_resp stable; cmd_ready stays 0 until the cycle after rsp_ready.
- rst pulsed asynchronously (off-edge) mid-WR_RESP -> all outputs 0 before the next clk edge; next command completes normally.
- With BANZAI_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never answers a read -> rsp_valid exactly 16 cycles after RD_REQ entry, rsp_resp 2'b10; without the macro, busy stays 1.

Source files
------------

// File: rtl/banzai_axil_host.sv
// banzai_axil_host: single-outstanding AXI-Lite master driving the banzAI control slave from a command/response stream.
// Optional B/R response timeout is compiled in when BANZAI_HOST_TIMEOUT_EN is defined.
module banzai_axil_host #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef BANZAI_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  // command / response stream
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  // AXI-Lite master
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  input  logic [1:0]              m_b_resp,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_valid,
  output logic                    m_r_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_RSP
  } state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic [1:0]            r_rsp_resp, w_rsp_resp_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done, w_w_done_nxt;
  logic                  w_accept;
  logic                  w_timeout;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;

`ifdef BANZAI_HOST_TIMEOUT_EN
  logic        w_waiting;
  logic [31:0] r_tmo_cnt;

  assign w_waiting = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) || (r_state == S_RD_RESP);

  // Counter reads TIMEOUT_CYCLES exactly as the block lands in RSP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_tmo_cnt <= '0;
    else if (w_accept)  r_tmo_cnt <= '0;
    else if (w_waiting) r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end

  assign w_timeout = w_waiting && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_resp_nxt = r_rsp_resp;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = cmd_write ? S_WR_REQ : S_RD_REQ;
        end
      end

      S_WR_REQ: begin
        // AW and W complete independently; B may coincide with the last of them.
        w_aw_done_nxt = r_aw_done || m_aw_ready;
        w_w_done_nxt  = r_w_done  || m_w_ready;
        if (w_aw_done_nxt && w_w_done_nxt && m_b_valid) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = m_b_resp;
          w_state_nxt    = S_RSP;
        end else if (w_timeout) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = RESP_SLVERR;
          w_state_nxt    = S_RSP;
        end else if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_b_valid) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = m_b_resp;
          w_state_nxt    = S_RSP;
        end else if (w_timeout) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = RESP_SLVERR;
          w_state_nxt    = S_RSP;
        end
      end

      S_RD_REQ: begin
        if (m_ar_ready && m_r_valid) begin
          w_rsp_data_nxt = m_r_data;
          w_rsp_resp_nxt = m_r_resp;
          w_state_nxt    = S_RSP;
        end else if (w_timeout) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = RESP_SLVERR;
          w_state_nxt    = S_RSP;
        end else if (m_ar_ready) begin
          w_state_nxt = S_RD_RESP;
        end
      end

      S_RD_RESP: begin
        if (m_r_valid) begin
          w_rsp_data_nxt = m_r_data;
          w_rsp_resp_nxt = m_r_resp;
          w_state_nxt    = S_RSP;
        end else if (w_timeout) begin
          w_rsp_data_nxt = '0;
          w_rsp_resp_nxt = RESP_SLVERR;
          w_state_nxt    = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rsp_data <= w_rsp_data_nxt;
      r_rsp_resp <= w_rsp_resp_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      if (w_accept) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_data;
      end
    end
  end

  // cmd_ready is gated by rst so the port reads 0 while reset is held.
  assign cmd_ready  = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = (r_state == S_RSP);
  assign rsp_data   = r_rsp_data;
  assign rsp_resp   = r_rsp_resp;

  assign m_aw_addr  = r_addr;
  assign m_aw_valid = (r_state == S_WR_REQ) && !r_aw_done;
  assign m_w_data   = r_wdata;
  assign m_w_strb   = '1;
  assign m_w_valid  = (r_state == S_WR_REQ) && !r_w_done;
  // The slave pulses B and R without waiting, so the readies are up for the whole wait.
  assign m_b_ready  = (r_state == S_WR_REQ) || (r_state == S_WR_RESP);
  assign m_ar_addr  = r_addr;
  assign m_ar_valid = (r_state == S_RD_REQ);
  assign m_r_ready  = (r_state == S_RD_REQ) || (r_state == S_RD_RESP);

endmodule
